// File: rtl/cluster_msip_sched_pkg.sv
// Shared constants and FSM encoding for the cluster msip sequencer.
package cluster_msip_sched_pkg;

  localparam int unsigned NumClusters       = 16;
  localparam int unsigned NrCores           = 9;
  localparam int unsigned MsipStaggerCycles = 4;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    GAP,
    DONE
  } msip_sched_state_e;

endpackage

// File: rtl/cluster_msip_sched_lzc.sv
// Trailing-zero counter: index of the lowest set bit, single-cycle combinational.
module cluster_msip_sched_lzc #(
  parameter int unsigned Width = 16,
  parameter int unsigned CntW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o
);

  // Scan from the top down so the lowest set bit wins; all-zero input yields 0.
  always_comb begin
    cnt_o = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CntW'(i);
    end
  end

endmodule

// File: rtl/cluster_msip_sched.sv
// Applies msip set/clear commands cluster by cluster in ascending order,
// with a programmable idle gap between clusters to spread core wake-ups.
module cluster_msip_sched #(
  parameter int unsigned NumClusters   = cluster_msip_sched_pkg::NumClusters,
  parameter int unsigned NrCores       = cluster_msip_sched_pkg::NrCores,
  parameter int unsigned StaggerCycles = cluster_msip_sched_pkg::MsipStaggerCycles
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_set_i,
  input  logic [NumClusters-1:0]              cmd_cluster_mask_i,
  input  logic [NrCores-1:0]                  cmd_core_mask_i,
  output logic [NumClusters-1:0][NrCores-1:0] msip_o,
  output logic                                busy_o,
  output logic                                done_o
);

  import cluster_msip_sched_pkg::*;

  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int unsigned CntW = (StaggerCycles > 0) ? $clog2(StaggerCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = (StaggerCycles > 0) ? CntW'(StaggerCycles - 1) : '0;

  msip_sched_state_e                 state_q, state_d;
  logic [NumClusters-1:0]            pend_q;
  logic [NumClusters-1:0]            pend_rest;
  logic [NrCores-1:0]                core_q;
  logic                              set_q;
  logic [CntW-1:0]                   cnt_q;
  logic                              done_q;
  logic [NumClusters-1:0][NrCores-1:0] msip_q;
  logic [IdxW-1:0]                   idx;
  logic                              cmd_hs;

  cluster_msip_sched_lzc #(
    .Width (NumClusters),
    .CntW  (IdxW)
  ) u_lzc (
    .in_i  (pend_q),
    .cnt_o (idx)
  );

  // done_o is registered, so hold off the next command until it has dropped.
  assign cmd_ready_o = (state_q == IDLE) && !done_q && !rst_i;
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign pend_rest   = pend_q & (pend_q - NumClusters'(1));
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign msip_o      = msip_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_hs) state_d = (cmd_cluster_mask_i != '0) ? APPLY : DONE;
      APPLY: begin
        if (pend_rest == '0)        state_d = DONE;
        else if (StaggerCycles > 0) state_d = GAP;
        else                        state_d = APPLY;
      end
      GAP:   if (cnt_q == '0) state_d = APPLY;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      core_q  <= '0;
      set_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      msip_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (cmd_hs) begin
        set_q  <= cmd_set_i;
        core_q <= cmd_core_mask_i;
        pend_q <= cmd_cluster_mask_i;
      end
      if (state_q == APPLY) begin
        pend_q[idx] <= 1'b0;
        msip_q[idx] <= set_q ? (msip_q[idx] | core_q) : (msip_q[idx] & ~core_q);
      end
      if (state_d == GAP && state_q != GAP) cnt_q <= CntLoad;
      else if (state_q == GAP && cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule
